// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding request/response handshake in front of
// a word-organised RAM, with a fixed number of wait states before each commit.
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              addr_err;
  logic [IDX_W-1:0]  idx;

  assign idx      = addr_q[IDX_W+1:2];
  // Any set bit above the index field puts the word beyond DEPTH.
  assign addr_err = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:IDX_W+2]);
  assign accept   = req_valid && req_ready;
  assign commit   = (state_q == S_WAIT) && (cnt_q == 4'(WAIT_STATES)) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (commit) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) && !rst;
    resp_valid = (state_q == S_RESP);
  end

  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
      cnt_d   = 4'd0;
    end
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 4'd1;
      if (commit) begin
        err_d   = addr_err;
        rdata_d = (write_q || addr_err) ? 32'd0 : mem[idx];
      end
    end
    if (state_q == S_RESP && resp_ready) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; commit already excludes a reset cycle.
  always_ff @(posedge clk) begin
    if (commit && write_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
